// File: rtl/wallace_pkg.sv
// Shared constants and state encoding for the six-operand 8-bit Wallace tree front end.
`default_nettype none

package wallace_pkg;
  localparam int N_OPS  = 6;
  localparam int OP_W   = 8;
  localparam int SUM_W  = 11;
  localparam int TREE_W = 10;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SUM     = 2'd1,
    HOLD    = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/operand_slot_bank.sv
// Six 8-bit operand slots with indexed write, synchronous clear and bit-major read-out.
`default_nettype none

module operand_slot_bank
  import wallace_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [CNT_W-1:0]               wr_idx,
  input  logic [OP_W-1:0]                wr_data,
  input  logic                           clr,
  output logic [OP_W-1:0][N_OPS-1:0]     x
);

  logic [N_OPS-1:0][OP_W-1:0] slots;

  for (genvar k = 0; k < N_OPS; k++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slots[k] <= '0;
      end else if (clr) begin
        slots[k] <= '0;
      end else if (wr_en && (wr_idx == CNT_W'(k))) begin
        slots[k] <= wr_data;
      end
    end
  end

  // Transpose: the tree consumes one column of six bits per bit position.
  for (genvar b = 0; b < OP_W; b++) begin : g_bit
    for (genvar k = 0; k < N_OPS; k++) begin : g_op
      assign x[b][k] = slots[k][b];
    end
  end

endmodule

`default_nettype wire

// File: rtl/operand_collector.sv
// Buffers up to six operands, feeds them transposed to the Wallace tree and returns the
// registered 11-bit sum; a serial running sum supplies bit 10 and cross-checks the tree.
`default_nettype none

module operand_collector
  import wallace_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [OP_W-1:0]             in_data,
  input  logic                        in_last,
  output logic [OP_W-1:0][N_OPS-1:0]  tree_x,
  input  logic [TREE_W-1:0]           tree_s,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SUM_W-1:0]            out_sum,
  output logic [CNT_W-1:0]            out_count,
  output logic                        out_err
);

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic [SUM_W-1:0]   run_sum;
  logic               accept;
  logic               group_done;
  logic               out_fire;

  always_comb begin
    in_ready   = (state == COLLECT);
    accept     = in_valid && in_ready;
    group_done = accept && (in_last || (cnt == CNT_W'(N_OPS - 1)));
    out_fire   = out_valid && out_ready;
    next_state = state;
    case (state)
      COLLECT: if (group_done) next_state = SUM;
      SUM:     next_state = HOLD;
      HOLD:    if (out_fire) next_state = COLLECT;
      default: next_state = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      run_sum <= '0;
    end else if (out_fire) begin
      cnt     <= '0;
      run_sum <= '0;
    end else if (accept) begin
      cnt     <= cnt + CNT_W'(1);
      run_sum <= run_sum + SUM_W'(in_data);
    end
  end

  operand_slot_bank u_slots (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_idx  (cnt),
    .wr_data (in_data),
    .clr     (out_fire),
    .x       (tree_x)
  );

  // The tree only produces 10 bits; bit 10 comes from the running sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_err   <= 1'b0;
    end else if (state == SUM) begin
      out_valid <= 1'b1;
      out_sum   <= {run_sum[SUM_W-1], tree_s};
      out_count <= cnt;
      out_err   <= (tree_s != run_sum[TREE_W-1:0]);
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire
